// File: rtl/serial_subtractor_4bit.sv
// ---------------------------------------------------------------------------
// serial_subtractor_4bit
//
// Bit-serial subtractor: computes {b_out, diff} = in1 - in2 - b_in using one
// 1-bit full-subtractor stage and shift registers. The operation runs LSB
// first over WIDTH shift cycles and is sequenced by a start/busy/done
// handshake.
//
// Optional feature macro: SERIAL_SUB_OVF_EN
//   When defined, adds the output ovf (signed two's-complement overflow).
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   request to begin; sampled only while idle
//   in1    in   minuend, latched on accepted start
//   in2    in   subtrahend, latched on accepted start
//   b_in   in   borrow-in, latched on accepted start
//   busy   out  high while shifting and during the done cycle
//   done   out  one-cycle pulse, diff/b_out (and ovf) valid
//   diff   out  difference, built LSB first
//   b_out  out  final unsigned borrow-out
//   ovf    out  signed overflow (only with SERIAL_SUB_OVF_EN)
// ---------------------------------------------------------------------------
module serial_subtractor_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // One full-subtractor stage: returns {borrow_out, difference_bit}.
    function automatic logic [1:0] full_sub(input logic a, input logic b, input logic br);
        logic d;
        logic bo;
        d  = a ^ b ^ br;
        bo = (~a & b) | (~(a ^ b) & br);
        return {bo, d};
    endfunction

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               borrow_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   diff_q;
    logic               b_out_q;
    logic               busy_q;
    logic               done_q;

    logic               d_bit_d;
    logic               borrow_d;
    logic [WIDTH-1:0]   diff_d;
    logic               last_shift_d;

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are kept separately because A and B are shifted away.
    logic               a_msb_q;
    logic               b_msb_q;
    logic               ovf_q;
`endif

    // Datapath for the current shift: subtractor bit, next borrow, next diff.
    always_comb begin
        {borrow_d, d_bit_d} = full_sub(a_q[0], b_q[0], borrow_q);
        diff_d              = {d_bit_d, diff_q[WIDTH-1:1]};
        last_shift_d        = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Control FSM and all registered datapath/outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            borrow_q <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            diff_q   <= {WIDTH{1'b0}};
            b_out_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q      <= in1;
                        b_q      <= in2;
                        borrow_q <= b_in;
                        cnt_q    <= {CNT_W{1'b0}};
                        busy_q   <= 1'b1;
                        state_q  <= ST_SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                        a_msb_q  <= in1[WIDTH-1];
                        b_msb_q  <= in2[WIDTH-1];
`endif
                    end else begin
                        // Idle: previous diff/b_out are held.
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    a_q      <= {1'b0, a_q[WIDTH-1:1]};
                    b_q      <= {1'b0, b_q[WIDTH-1:1]};
                    borrow_q <= borrow_d;
                    diff_q   <= diff_d;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    busy_q   <= 1'b1;
                    if (last_shift_d) begin
                        b_out_q <= borrow_d;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
`ifdef SERIAL_SUB_OVF_EN
                        // d_bit_d is the MSB of the completed difference.
                        ovf_q   <= (a_msb_q != b_msb_q) && (d_bit_d != a_msb_q);
`endif
                    end else begin
                        done_q  <= 1'b0;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign diff  = diff_q;
    assign b_out = b_out_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor_4bit
//
// Directed-vector bench for serial_subtractor_4bit (WIDTH=4). Expected values
// are hand-computed constants. With SERIAL_SUB_OVF_EN defined the ovf output
// is connected and checked as well.
// ---------------------------------------------------------------------------
module tb_serial_subtractor_4bit;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             b_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    int checks_r;
    int failures_r;

    serial_subtractor_4bit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in1   (in1),
        .in2   (in2),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .b_out (b_out)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r++;
        if (obs !== exp) begin
            failures_r++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Runs one operation. Start is sampled at edge k; done must rise on edge
    // k+WIDTH. When disturb is set, start is re-asserted with junk operands
    // throughout SHIFT and DONE, which must be ignored.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic bi, input logic [WIDTH-1:0] exp_diff, input logic exp_bout,
                          input logic disturb);
        int n;
        @(negedge clk);
        in1   = x;
        in2   = y;
        b_in  = bi;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        n = 0;
        while (n < 20 && done !== 1'b1) begin
            if (disturb) begin
                start = 1'b1;
                in1   = 4'hF - x;
                in2   = 4'hF - y;
                b_in  = ~bi;
            end
            @(posedge clk);
            #1;
            n++;
        end
        // Start must be low again before DONE returns to IDLE.
        start = 1'b0;
        check_eq({tag, "_latency"}, 32'(n), 32'(WIDTH));
        check_eq({tag, "_diff"}, 32'(diff), 32'(exp_diff));
        check_eq({tag, "_b_out"}, 32'(b_out), 32'(exp_bout));
        @(posedge clk);
        #1;
        check_eq({tag, "_done_pulse_end"}, 32'({busy, done}), 32'd0);
    endtask

    initial begin
        int n_done;
        checks_r   = 0;
        failures_r = 0;

        // Reset with arbitrary inputs applied.
        rst   = 1'b1;
        start = 1'b1;
        in1   = 4'($urandom);
        in2   = 4'($urandom);
        b_in  = 1'($urandom);
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_outputs", 32'({busy, done, diff, b_out}), 32'd0);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_eq("idle_after_reset", 32'({busy, done, diff, b_out}), 32'd0);
        end

        // 5 - 7 = -2 -> 1110, borrow
        run_op("sub_5_7", 4'd5, 4'd7, 1'b0, 4'b1110, 1'b1, 1'b0);
        // Result must hold in IDLE.
        repeat (5) @(posedge clk);
        #1;
        check_eq("idle_hold", 32'({busy, done, diff, b_out}), 32'({1'b0, 1'b0, 4'b1110, 1'b1}));

        run_op("sub_12_6", 4'd12, 4'd6, 1'b0, 4'd6, 1'b0, 1'b0);
        run_op("sub_14_6_b", 4'd14, 4'd6, 1'b1, 4'd7, 1'b0, 1'b0);
        run_op("sub_0_0_b", 4'd0, 4'd0, 1'b1, 4'b1111, 1'b1, 1'b0);
        run_op("sub_2_1_b", 4'd2, 4'd1, 1'b1, 4'd0, 1'b0, 1'b0);

        // Start and operands toggled while busy: first operands win, no queueing.
        run_op("sub_9_3_dist", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("no_queued_op", 32'({busy, done}), 32'd0);

        // Reset during the second shift aborts the operation.
        @(negedge clk);
        in1   = 4'd15;
        in2   = 4'd0;
        b_in  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        check_eq("midshift_reset_outputs", 32'({busy, done, diff, b_out}), 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) n_done++;
        end
        check_eq("midshift_reset_no_done", 32'(n_done), 32'd0);
        check_eq("midshift_reset_idle", 32'({busy, diff, b_out}), 32'd0);
        run_op("sub_10_3_after_rst", 4'd10, 4'd3, 1'b0, 4'd7, 1'b0, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
        // -8 - 1 overflows to +7; 3 - 1 does not overflow.
        run_op("ovf_8_1", 4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 1'b0);
        check_eq("ovf_8_1_ovf", 32'(ovf), 32'd1);
        run_op("ovf_3_1", 4'd3, 4'd1, 1'b0, 4'd2, 1'b0, 1'b0);
        check_eq("ovf_3_1_ovf", 32'(ovf), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
